cim_cmd_responder: RTL and testbench

- Responder end of the compute-in-memory controller's host interface: owns a 64-word x 16-bit operand store.
- Services one-cycle external load/store commands (ExLdSt) and multi-cycle lane-wise compute commands (Compute valid/ready).
- Sits below the superior controller, which drives ExLdSt_* and Compute_*.
- Serves as the synthesizable command-execution front end and as the golden model for host-side benches.

---
 rtl/cim_pkg.sv | 43 ++++
 rtl/cim_lane_mul.sv | 110 +++++++++++
 rtl/cim_cmd_responder.sv | 197 +++++++++++++++++++
 tb/tb_cim_cmd_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared codes, command field offsets and FSM states for the CIM command responder
package cim_pkg;

    localparam logic [2:0] MODE_NOP = 3'b000;
    localparam logic [2:0] MODE_OR  = 3'b001;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_XOR = 3'b011;
    localparam logic [2:0] MODE_ADD = 3'b100;
    localparam logic [2:0] MODE_SUB = 3'b101;
    localparam logic [2:0] MODE_NOT = 3'b110;
    localparam logic [2:0] MODE_MUL = 3'b111;

    localparam logic [2:0] LEN_INT4  = 3'b001;
    localparam logic [2:0] LEN_INT8  = 3'b010;
    localparam logic [2:0] LEN_INT16 = 3'b011;

    localparam int CMD_WIDTH    = 25;
    localparam int CMD_SPEC_BIT = 24;
    localparam int CMD_MODE_LSB = 21;
    localparam int CMD_LEN_LSB  = 18;
    localparam int CMD_RS1_LSB  = 12;
    localparam int CMD_RS2_LSB  = 6;
    localparam int CMD_RD_LSB   = 0;

    localparam int EXLDST_WR_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } cim_state_e;

    // Lane width in bits; reserved length codes fall back to a single full-width lane.
    function automatic int lane_width(input logic [2:0] len);
        case (len)
            LEN_INT4:  return 4;
            LEN_INT8:  return 8;
            LEN_INT16: return 16;
            default:   return 16;
        endcase
    endfunction

endpackage

// File: rtl/cim_lane_mul.sv
// rtl/cim_lane_mul.sv - lane-segmented sequential shift-add multiplier
module cim_lane_mul
    import cim_pkg::*;
#(
    parameter int ROW_NUM = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         length,
    input  logic               spec,
    input  logic [ROW_NUM-1:0] op_a,
    input  logic [ROW_NUM-1:0] op_b,
    output logic [ROW_NUM-1:0] result,
    output logic               done
);

    localparam int STEP_W = $clog2(ROW_NUM);

    // Each lane of width w keeps a 2w-bit partial product; lanes pack into 2*ROW_NUM bits.
    logic [2*ROW_NUM-1:0] acc;
    logic [2*ROW_NUM-1:0] acc_next;
    logic [2*ROW_NUM-1:0] seg;
    logic [STEP_W-1:0]    step;
    logic                 busy;
    int                   w;

    // One shift-add step for a single lane. In signed mode the multiplicand is
    // sign-extended and the partial product of the multiplier's sign bit is
    // subtracted, which yields the two's-complement product modulo 2^(2w).
    function automatic logic [2*ROW_NUM-1:0] lane_step(
        input logic [2*ROW_NUM-1:0] acc_l,
        input logic [ROW_NUM-1:0]   a_l,
        input logic [ROW_NUM-1:0]   b_l,
        input int                   lw,
        input logic [STEP_W-1:0]    k,
        input logic                 sgn
    );
        logic [2*ROW_NUM-1:0] lmask;
        logic [2*ROW_NUM-1:0] ext;
        logic [2*ROW_NUM-1:0] pp;
        logic [2*ROW_NUM-1:0] sum;
        logic [ROW_NUM-1:0]   a_top;
        lmask = ~({2*ROW_NUM{1'b1}} << lw);
        ext   = {{ROW_NUM{1'b0}}, a_l} & lmask;
        a_top = a_l >> (lw - 1);
        if (sgn && a_top[0]) begin
            ext = ext | ~lmask;
        end
        pp = b_l[k] ? (ext << k) : '0;
        if (sgn && (int'(k) == lw - 1)) begin
            sum = acc_l - pp;
        end else begin
            sum = acc_l + pp;
        end
        return sum & ~({2*ROW_NUM{1'b1}} << (2 * lw));
    endfunction

    // Lane width follows the latched length code of the command being executed.
    always_comb begin
        w = lane_width(length);
    end

    assign done = busy && (int'(step) == w - 1);

    // Accumulator value after applying the current step to every active lane.
    always_comb begin
        acc_next = '0;
        for (int i = 0; i < ROW_NUM / 4; i++) begin
            if (w * i < ROW_NUM) begin
                acc_next = acc_next |
                    (lane_step(acc >> (2 * w * i), op_a >> (w * i), op_b >> (w * i), w, step, spec)
                     << (2 * w * i));
            end
        end
    end

    // Result includes the step applied on the final edge: low half (unsigned) or high half (signed).
    always_comb begin
        result = '0;
        seg    = '0;
        for (int i = 0; i < ROW_NUM / 4; i++) begin
            if (w * i < ROW_NUM) begin
                seg    = acc_next >> (2 * w * i + (spec ? w : 0));
                result = result | ((ROW_NUM'(seg) & ~({ROW_NUM{1'b1}} << w)) << (w * i));
            end
        end
    end

    // Step sequencing: start clears the accumulator, then one multiplier bit per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            step <= '0;
            busy <= 1'b0;
        end else if (start) begin
            acc  <= '0;
            step <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc <= acc_next;
            if (done) begin
                busy <= 1'b0;
            end else begin
                step <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cim_cmd_responder.sv
// rtl/cim_cmd_responder.sv - operand store with load/store port and lane-wise compute engine
module cim_cmd_responder
    import cim_pkg::*;
#(
    parameter int COL_NUM_BIT = 6,
    parameter int ROW_NUM     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ExLdSt_valid,
    input  logic [COL_NUM_BIT:0] ExLdSt_command,
    inout  logic [ROW_NUM-1:0]   ExLdSt_data,
    input  logic                 Compute_valid,
    output logic                 Compute_ready,
    input  logic [CMD_WIDTH-1:0] Compute_command
);

    localparam int DEPTH = 1 << COL_NUM_BIT;
    localparam int CNT_W = $clog2(ROW_NUM);

    logic [ROW_NUM-1:0]     mem [DEPTH];

    cim_state_e             state;
    cim_state_e             state_next;
    logic                   accept;
    logic                   finish;

    logic [2:0]             mode_q;
    logic [2:0]             len_q;
    logic                   spec_q;
    logic [COL_NUM_BIT-1:0] rd_q;
    logic [ROW_NUM-1:0]     op_a;
    logic [ROW_NUM-1:0]     op_b;
    logic [CNT_W-1:0]       cnt;

    logic [ROW_NUM-1:0]     alu_result;
    logic [ROW_NUM-1:0]     mul_result;
    logic                   mul_done;
    logic                   mul_start;

    logic [COL_NUM_BIT-1:0] ex_addr;
    logic                   ex_wr;
    logic                   ex_rd;

    logic [2:0]             c_mode;
    logic [2:0]             c_len;
    logic [COL_NUM_BIT-1:0] c_rs1;
    logic [COL_NUM_BIT-1:0] c_rs2;
    logic [COL_NUM_BIT-1:0] c_rd;

    assign ex_addr = ExLdSt_command[COL_NUM_BIT-1:0];
    assign ex_wr   = ExLdSt_valid && ExLdSt_command[EXLDST_WR_BIT];
    assign ex_rd   = ExLdSt_valid && !ExLdSt_command[EXLDST_WR_BIT];

    assign c_mode = Compute_command[CMD_MODE_LSB +: 3];
    assign c_len  = Compute_command[CMD_LEN_LSB +: 3];
    assign c_rs1  = Compute_command[CMD_RS1_LSB +: COL_NUM_BIT];
    assign c_rs2  = Compute_command[CMD_RS2_LSB +: COL_NUM_BIT];
    assign c_rd   = Compute_command[CMD_RD_LSB +: COL_NUM_BIT];

    // Reads are combinational in the command cycle; the bus is released otherwise.
    assign ExLdSt_data = ex_rd ? mem[ex_addr] : {ROW_NUM{1'bz}};

    assign mul_start = accept && (c_mode == MODE_MUL);

    // Lane-wise add/subtract with carries confined to each lane.
    function automatic logic [ROW_NUM-1:0] lane_addsub(
        input logic [ROW_NUM-1:0] a,
        input logic [ROW_NUM-1:0] b,
        input int                 lw,
        input logic               sub
    );
        logic [ROW_NUM-1:0] r;
        logic [ROW_NUM-1:0] lmask;
        logic [ROW_NUM-1:0] x;
        logic [ROW_NUM-1:0] y;
        logic [ROW_NUM-1:0] s;
        r     = '0;
        lmask = ~({ROW_NUM{1'b1}} << lw);
        for (int i = 0; i < ROW_NUM / 4; i++) begin
            if (lw * i < ROW_NUM) begin
                x = (a >> (lw * i)) & lmask;
                y = (b >> (lw * i)) & lmask;
                s = sub ? (x - y) : (x + y);
                r = r | ((s & lmask) << (lw * i));
            end
        end
        return r;
    endfunction

    cim_lane_mul #(
        .ROW_NUM (ROW_NUM)
    ) u_lane_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .length (len_q),
        .spec   (spec_q),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (mul_result),
        .done   (mul_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, acceptance, writeback strobe and ready pulse.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        finish        = 1'b0;
        Compute_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Compute_valid) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((cnt == '0) && ((mode_q != MODE_MUL) || mul_done)) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                Compute_ready = 1'b1;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command and operand capture at acceptance; cycle counter during EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_NOP;
            len_q  <= '0;
            spec_q <= 1'b0;
            rd_q   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mode_q <= c_mode;
            len_q  <= c_len;
            spec_q <= Compute_command[CMD_SPEC_BIT];
            rd_q   <= c_rd;
            op_a   <= mem[c_rs1];
            op_b   <= mem[c_rs2];
            cnt    <= (c_mode == MODE_MUL) ? CNT_W'(lane_width(c_len) - 1) : '0;
        end else if ((state == ST_EXEC) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Result selection for the latched mode.
    always_comb begin
        alu_result = '0;
        case (mode_q)
            MODE_OR:  alu_result = op_a | op_b;
            MODE_AND: alu_result = op_a & op_b;
            MODE_XOR: alu_result = op_a ^ op_b;
            MODE_ADD: alu_result = lane_addsub(op_a, op_b, lane_width(len_q), 1'b0);
            MODE_SUB: alu_result = lane_addsub(op_a, op_b, lane_width(len_q), 1'b1);
            MODE_NOT: alu_result = ~op_a;
            MODE_MUL: alu_result = mul_result;
            default:  alu_result = '0;
        endcase
    end

    // Store writes; the host write is placed last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (finish && (mode_q != MODE_NOP)) begin
                mem[rd_q] <= alu_result;
            end
            if (ex_wr) begin
                mem[ex_addr] <= ExLdSt_data;
            end
        end
    end

endmodule

// File: tb/tb_cim_cmd_responder.sv
// tb/tb_cim_cmd_responder.sv - self-checking bench for cim_cmd_responder
module tb_cim_cmd_responder;
    import cim_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ExLdSt_valid;
    logic [6:0]  ExLdSt_command;
    wire  [15:0] ExLdSt_data;
    logic        drv_en;
    logic [15:0] drv_val;
    logic        Compute_valid;
    logic        Compute_ready;
    logic [24:0] Compute_command;

    int          nvec = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [15:0] mdl [64];

    assign ExLdSt_data = drv_en ? drv_val : 16'hzzzz;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cim_cmd_responder #(
        .COL_NUM_BIT (6),
        .ROW_NUM     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ExLdSt_valid    (ExLdSt_valid),
        .ExLdSt_command  (ExLdSt_command),
        .ExLdSt_data     (ExLdSt_data),
        .Compute_valid   (Compute_valid),
        .Compute_ready   (Compute_ready),
        .Compute_command (Compute_command)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pre;
        logic [24:0] cmd;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t tv [17];

    function automatic logic [24:0] mk(input logic s, input logic [2:0] mo, input logic [2:0] ln,
                                       input logic [5:0] r1, input logic [5:0] r2, input logic [5:0] d);
        return {s, mo, ln, r1, r2, d};
    endfunction

    function automatic int lw_of(input logic [2:0] ln);
        if (ln == 3'b001) return 4;
        if (ln == 3'b010) return 8;
        return 16;
    endfunction

    // Reference: per-lane integer arithmetic, lanes handled one at a time.
    function automatic logic [15:0] ref_op(input logic [2:0] mo, input logic [2:0] ln, input logic s,
                                           input logic [15:0] a, input logic [15:0] b);
        int          w;
        longint      m;
        longint      x;
        longint      y;
        longint      z;
        longint      sx;
        longint      sy;
        logic [15:0] r;
        w = lw_of(ln);
        m = (longint'(1) << w) - 1;
        r = '0;
        for (int i = 0; i < 16 / w; i++) begin
            x = longint'(a >> (i * w)) & m;
            y = longint'(b >> (i * w)) & m;
            case (mo)
                3'd1: z = x | y;
                3'd2: z = x & y;
                3'd3: z = x ^ y;
                3'd4: z = x + y;
                3'd5: z = x - y;
                3'd6: z = ~x;
                3'd7: begin
                    if (!s) begin
                        z = x * y;
                    end else begin
                        sx = (x > (m >> 1)) ? x - (m + 1) : x;
                        sy = (y > (m >> 1)) ? y - (m + 1) : y;
                        z  = (sx * sy) >>> w;
                    end
                end
                default: z = 0;
            endcase
            r = r | 16'((z & m) << (i * w));
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic host_wr(input logic [5:0] a, input logic [15:0] d);
        ExLdSt_valid   = 1'b1;
        ExLdSt_command = {1'b1, a};
        drv_en         = 1'b1;
        drv_val        = d;
        @(posedge clk);
        #1;
        ExLdSt_valid = 1'b0;
        drv_en       = 1'b0;
        mdl[a]       = d;
    endtask

    task automatic host_rd(input logic [5:0] a, output logic [15:0] d);
        ExLdSt_valid   = 1'b1;
        ExLdSt_command = {1'b0, a};
        @(negedge clk);
        d = ExLdSt_data;
        @(posedge clk);
        #1;
        ExLdSt_valid = 1'b0;
    endtask

    task automatic start_cmd(input logic [24:0] c);
        Compute_valid   = 1'b1;
        Compute_command = c;
        @(posedge clk);
        #1;
        acc_cyc         = cyc;
        Compute_command = 25'($urandom);
    endtask

    task automatic wait_ready(input int exp_lat, input string nm);
        bit seen;
        int n;
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clk);
            if (Compute_ready) seen = 1'b1;
        end
        n = seen ? (cyc - acc_cyc + 1) : -1;
        Compute_valid = 1'b0;
        check({nm, " latency"}, n, exp_lat);
        @(posedge clk);
        #1;
        check({nm, " ready width"}, {31'd0, Compute_ready}, 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic [5:0]  r1, r2, rdx;
        logic [2:0]  mo, ln;
        logic        s;
        logic [15:0] e;
        int          pulses;
        int          nonzero;

        for (int i = 0; i < 64; i++) mdl[i] = '0;
        rst             = 1'b1;
        ExLdSt_valid    = 1'b0;
        ExLdSt_command  = '0;
        drv_en          = 1'b0;
        drv_val         = '0;
        Compute_valid   = 1'b0;
        Compute_command = '0;

        tv[0]  = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_AND, LEN_INT8,  1, 2, 3),  16'h0026, 2};
        tv[1]  = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_MUL, LEN_INT8,  1, 2, 5),  16'h00A2, 9};
        tv[2]  = '{16'h0037, 16'h006E, 16'h0000, mk(1, MODE_MUL, LEN_INT8,  1, 2, 5),  16'h0017, 9};
        tv[3]  = '{16'h00F0, 16'h0003, 16'h0000, mk(1, MODE_MUL, LEN_INT8,  1, 2, 6),  16'h00FF, 9};
        tv[4]  = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_ADD, LEN_INT4,  1, 2, 7),  16'h0095, 2};
        tv[5]  = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_SUB, LEN_INT4,  1, 2, 8),  16'h00D9, 2};
        tv[6]  = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_OR,  LEN_INT16, 1, 2, 9),  16'h007F, 2};
        tv[7]  = '{16'h0037, 16'h006E, 16'h0000, mk(1, MODE_NOT, LEN_INT16, 1, 2, 10), 16'hFFC8, 2};
        tv[8]  = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_MUL, LEN_INT4,  1, 2, 11), 16'h0022, 5};
        tv[9]  = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_MUL, LEN_INT16, 1, 2, 12), 16'h17A2, 17};
        tv[10] = '{16'hFFFF, 16'h0002, 16'h0000, mk(1, MODE_MUL, LEN_INT16, 1, 2, 13), 16'hFFFF, 17};
        tv[11] = '{16'h80FF, 16'h8001, 16'hFFFF, mk(0, MODE_ADD, LEN_INT8,  1, 2, 14), 16'h0000, 2};
        tv[12] = '{16'h0037, 16'h006E, 16'hBEEF, mk(1, MODE_NOP, LEN_INT4,  1, 2, 15), 16'hBEEF, 2};
        tv[13] = '{16'h00FF, 16'h0001, 16'h0000, mk(0, MODE_ADD, 3'b000,    1, 2, 16), 16'h0100, 2};
        tv[14] = '{16'h0000, 16'h0001, 16'h0000, mk(0, MODE_SUB, 3'b101,    1, 2, 17), 16'hFFFF, 2};
        tv[15] = '{16'h0037, 16'h006E, 16'h0000, mk(0, MODE_XOR, LEN_INT8,  1, 2, 1),  16'h0059, 2};
        tv[16] = '{16'h00F7, 16'h0023, 16'h0000, mk(1, MODE_MUL, LEN_INT4,  1, 2, 18), 16'h00F1, 5};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset ready", {31'd0, Compute_ready}, 32'd0);
        host_rd(6'd0, d);
        check("reset mem0", d, 16'h0000);
        host_rd(6'd63, d);
        check("reset mem63", d, 16'h0000);

        host_wr(6'd1, 16'hAA55);
        host_rd(6'd1, d);
        check("write then read", d, 16'hAA55);

        for (int i = 0; i < 17; i++) begin
            host_wr(tv[i].cmd[5:0], tv[i].pre);
            host_wr(6'd1, tv[i].a);
            host_wr(6'd2, tv[i].b);
            start_cmd(tv[i].cmd);
            wait_ready(tv[i].lat, $sformatf("vec%0d", i));
            host_rd(tv[i].cmd[5:0], d);
            check($sformatf("vec%0d result", i), d, tv[i].exp);
            mdl[tv[i].cmd[5:0]] = tv[i].exp;
        end

        for (int it = 0; it < 40; it++) begin
            r1  = 6'($urandom_range(0, 63));
            r2  = 6'($urandom_range(0, 63));
            rdx = 6'($urandom_range(0, 63));
            mo  = 3'($urandom);
            ln  = 3'($urandom);
            s   = 1'($urandom);
            if ($urandom_range(0, 1) == 1) host_wr(r1, 16'($urandom));
            if ($urandom_range(0, 1) == 1) host_wr(r2, 16'($urandom));
            e = ref_op(mo, ln, s, mdl[r1], mdl[r2]);
            start_cmd(mk(s, mo, ln, r1, r2, rdx));
            wait_ready(((mo == MODE_MUL) ? lw_of(ln) : 1) + 1, $sformatf("rand%0d", it));
            if (mo != MODE_NOP) mdl[rdx] = e;
            host_rd(rdx, d);
            check($sformatf("rand%0d result m%0d l%0d s%0d", it, mo, ln, s), d, mdl[rdx]);
        end

        // Operand overwrite during EXEC, and read of rd in the writeback cycle.
        host_wr(6'd1, 16'h0037);
        host_wr(6'd2, 16'h006E);
        host_wr(6'd5, 16'h5555);
        start_cmd(mk(0, MODE_MUL, LEN_INT8, 1, 2, 5));
        repeat (2) @(posedge clk);
        #1;
        host_wr(6'd1, 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        host_rd(6'd5, d);
        check("read rd in writeback cycle", d, 16'h5555);
        wait_ready(9, "operand latch");
        host_rd(6'd5, d);
        check("operand latch result", d, 16'h00A2);

        // Host write to rd on the writeback edge takes priority.
        host_wr(6'd1, 16'h0037);
        start_cmd(mk(0, MODE_MUL, LEN_INT8, 1, 2, 5));
        repeat (7) @(posedge clk);
        #1;
        host_wr(6'd5, 16'h1234);
        wait_ready(9, "collision");
        host_rd(6'd5, d);
        check("collision host wins", d, 16'h1234);

        // Reset in the fifth EXEC cycle of a MUL int16.
        host_wr(6'd1, 16'h0037);
        host_wr(6'd2, 16'h006E);
        start_cmd(mk(0, MODE_MUL, LEN_INT16, 1, 2, 7));
        repeat (4) @(posedge clk);
        #1;
        Compute_valid = 1'b0;
        rst           = 1'b1;
        pulses        = 0;
        @(negedge clk);
        if (Compute_ready) pulses++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (Compute_ready) pulses++;
        end
        @(posedge clk);
        #1;
        check("ready after abort", pulses, 0);
        nonzero = 0;
        for (int i = 0; i < 64; i++) begin
            host_rd(6'(i), d);
            if (d != 16'h0000) nonzero++;
            mdl[i] = '0;
        end
        check("store cleared by reset", nonzero, 0);
        host_wr(6'd1, 16'h0037);
        host_wr(6'd2, 16'h006E);
        start_cmd(mk(0, MODE_XOR, LEN_INT16, 1, 2, 3));
        wait_ready(2, "post-reset xor");
        host_rd(6'd3, d);
        check("post-reset xor result", d, 16'h0059);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
